// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronises and debounces one raw pin, then turns
// the clean level into one-cycle press / auto-repeat / release event pulses.
module button_conditioner #(
  parameter bit          ACTIVE_HIGH          = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES      = 120000,
  parameter bit          REPEAT_ENABLE        = 1'b1,
  parameter int unsigned REPEAT_DELAY_CYCLES  = 6000000,
  parameter int unsigned REPEAT_PERIOD_CYCLES = 1200000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_button,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RcMax = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                  REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int unsigned RcW   = $clog2(RcMax) + 1;

  localparam logic [DbW-1:0] DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RcW-1:0] DelayLast  = RcW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RcW-1:0] PeriodLast = RcW'(REPEAT_PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHeldDelay,
    StHeldRepeat
  } state_e;

  // Pin normalised so that 1 always means "pressed".
  logic pin;
  assign pin = ACTIVE_HIGH ? i_button : ~i_button;

  logic           sync1_q, sync2_q;
  logic [DbW-1:0] db_q, db_d;
  logic           pressed_q, pressed_d;
  logic           rise, fall;
  state_e         state_q, state_d;
  logic [RcW-1:0] rc_q, rc_d;
  logic           press_q, press_d;
  logic           release_q, release_d;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_d      = '0;
    pressed_d = pressed_q;
    if (sync2_q != pressed_q) begin
      if (db_q == DbLast) begin
        pressed_d = sync2_q;
      end else begin
        db_d = db_q + 1'b1;
      end
    end
  end

  // Level changes are known a cycle early so pulses line up with o_pressed.
  assign rise = ~pressed_q & pressed_d;
  assign fall = pressed_q & ~pressed_d;

  // Debounce state and FSM state register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      db_q      <= '0;
      pressed_q <= 1'b0;
      state_q   <= StIdle;
      rc_q      <= '0;
    end else begin
      db_q      <= db_d;
      pressed_q <= pressed_d;
      state_q   <= state_d;
      rc_q      <= rc_d;
    end
  end

  // Next-state and repeat-counter logic; release always wins over a repeat.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StHeldDelay;
          rc_d    = '0;
        end
      end
      StHeldDelay: begin
        if (fall) begin
          state_d = StIdle;
          rc_d    = '0;
        end else if (rc_q == DelayLast) begin
          // Without repeat the counter simply parks at its terminal value.
          if (REPEAT_ENABLE) begin
            state_d = StHeldRepeat;
            rc_d    = '0;
          end
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      StHeldRepeat: begin
        if (fall) begin
          state_d = StIdle;
          rc_d    = '0;
        end else if (rc_q == PeriodLast) begin
          rc_d = '0;
        end else begin
          rc_d = rc_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        rc_d    = '0;
      end
    endcase
  end

  // Pulse decode from current state; registered below.
  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        press_d = rise;
      end
      StHeldDelay: begin
        release_d = fall;
        press_d   = ~fall & REPEAT_ENABLE & (rc_q == DelayLast);
      end
      StHeldRepeat: begin
        release_d = fall;
        press_d   = ~fall & (rc_q == PeriodLast);
      end
      default: begin
        press_d   = 1'b0;
        release_d = 1'b0;
      end
    endcase
  end

  // Registered event pulses.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign o_pressed       = pressed_q;
  assign o_press_pulse   = press_q;
  assign o_release_pulse = release_q;

endmodule
